// File: rtl/dmem_if.sv
// Load/store port between the core (master) and the data-memory responder (slave).
interface dmem_if #(
   parameter int unsigned ADDR_W = 10
) ();
   logic [ADDR_W-1:0] DIR_DMEM;
   logic [31:0]       DATA_WRITE_DMEM;
   logic              READ;
   logic              WRITE;
   logic [1:0]        SIZE;
   logic              UNSIGNED;
   logic [31:0]       DATA_READ_DMEM;
   logic              RDATA_VALID;
   logic              STALL;
   logic              ERR;

   modport master (
      output DIR_DMEM, DATA_WRITE_DMEM, READ, WRITE, SIZE, UNSIGNED,
      input  DATA_READ_DMEM, RDATA_VALID, STALL, ERR
   );

   modport slave (
      input  DIR_DMEM, DATA_WRITE_DMEM, READ, WRITE, SIZE, UNSIGNED,
      output DATA_READ_DMEM, RDATA_VALID, STALL, ERR
   );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: byte/half/word loads and stores, little-endian lanes,
// word-crossing accesses split into two array cycles with a one-cycle stall.
module dmem_responder #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 10
) (
   input logic   CLK,
   input logic   RST_n,
   dmem_if.slave bus
);
   localparam int unsigned IdxW  = ADDR_W - 2;
   localparam int unsigned Depth = 2 ** IdxW;

   typedef enum logic {StIdle, StSecond} state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] mem_q [Depth];
   logic [31:0]       hold_q, hold_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              rvalid_q, rvalid_d;
   logic              err_q, err_d;

   logic [1:0]        off;
   logic [IdxW-1:0]   idx, idx_nxt;
   logic              legal, illegal, crossing;
   logic [3:0]        size_mask;
   logic [7:0]        be;
   logic [63:0]       wdata_sh;
   logic [31:0]       word_lo, word_hi, raw, fmt;
   logic              we;
   logic [IdxW-1:0]   waddr;
   logic [3:0]        wbe;
   logic [31:0]       wdata;

   assign off     = bus.DIR_DMEM[1:0];
   assign idx     = bus.DIR_DMEM[ADDR_W-1:2];
   assign idx_nxt = idx + 1'b1;
   assign legal   = (bus.READ ^ bus.WRITE) && (bus.SIZE != 2'b11);
   assign illegal = (bus.READ | bus.WRITE) && !legal;

   always_comb begin
      size_mask = 4'b0000;
      case (bus.SIZE)
         2'b00:   size_mask = 4'b0001;
         2'b01:   size_mask = 4'b0011;
         2'b10:   size_mask = 4'b1111;
         default: size_mask = 4'b0000;
      endcase
   end

   // Lanes spilling into be[7:4] belong to the next word, so that is the split condition.
   assign be       = {4'b0000, size_mask} << off;
   assign crossing = |be[7:4];
   assign wdata_sh = {32'h0, bus.DATA_WRITE_DMEM} << {off, 3'b000};

   always_comb begin
      word_lo = mem_q[idx];
      word_hi = '0;
      if (state_q == StSecond) begin
         word_lo = hold_q;
         word_hi = mem_q[idx_nxt];
      end
   end

   assign raw = 32'({word_hi, word_lo} >> {off, 3'b000});

   always_comb begin
      fmt = raw;
      case (bus.SIZE)
         2'b00:   fmt = bus.UNSIGNED ? {24'h0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
         2'b01:   fmt = bus.UNSIGNED ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
         default: fmt = raw;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      rdata_d   = rdata_q;
      rvalid_d  = 1'b0;
      err_d     = 1'b0;
      we        = 1'b0;
      waddr     = idx;
      wbe       = be[3:0];
      wdata     = wdata_sh[31:0];
      bus.STALL = 1'b0;
      unique case (state_q)
         StIdle: begin
            err_d = illegal;
            if (legal) begin
               we = bus.WRITE;
               if (crossing) begin
                  bus.STALL = 1'b1;
                  state_d   = StSecond;
                  if (bus.READ) hold_d = word_lo;
               end else if (bus.READ) begin
                  rdata_d  = fmt;
                  rvalid_d = 1'b1;
               end
            end
         end
         StSecond: begin
            // Request inputs are held stable by the core while stalled.
            state_d = StIdle;
            we      = bus.WRITE;
            waddr   = idx_nxt;
            wbe     = be[7:4];
            wdata   = wdata_sh[63:32];
            if (bus.READ) begin
               rdata_d  = fmt;
               rvalid_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (wbe[b]) mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state_q  <= StIdle;
         hold_q   <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         hold_q   <= hold_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
         err_q    <= err_d;
      end
   end

   assign bus.DATA_READ_DMEM = rdata_q;
   assign bus.RDATA_VALID    = rvalid_q;
   assign bus.ERR            = err_q;
endmodule
